fft_stage_write_ctrl: RTL and testbench
=======================================

FFT_STAGE_WRITE_CTRL -- requirements
Module: fft_stage_write_ctrl

Interface
REQ-001 Parameter LOG2N, default 8, log2 of frame length and address width.
REQ-002 Parameter DW, default 32, sample width (packed re[31:16], im[15:0]).
REQ-003 Parameter BITREV, default 1, where 1 selects bit-reversed write addressing and 0 selects natural order.
REQ-004 One clock, clock_c; reset reset_n is asynchronous and active-low.
REQ-005 clock_c  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 ce  in  1  stage clock-enable; shared with the downstream ping-pong buffer.
REQ-008 clear  in  1  synchronous abort; also driven to the downstream buffer's clear.
REQ-009 frame_start  in  1  marks the first sample of a frame.
REQ-010 din_valid  in  1  din carries a sample this cycle.
REQ-011 din  in  DW  input sample.
REQ-012 wr_data  out  DW  registered sample to the buffer.
REQ-013 wr_addr  out  LOG2N  registered buffer write address.
REQ-014 wr_en  out  1  registered buffer write strobe.
REQ-015 start  out  1  one-cycle pulse after a full frame is written; drives the downstream buffer's start input.
REQ-016 bank  out  1  toggles with every start pulse; mirrors the buffer read bank.
REQ-017 short_frame  out  1  sticky error flag for a frame_start arriving mid-frame.

Function
REQ-018 All registers SHALL hold their values when ce=0 and update only on rising edges with ce=1, except reset.
REQ-019 States: IDLE and FILL; reset state IDLE.
REQ-020 In IDLE, din_valid without frame_start SHALL be ignored, with wr_en=0 next cycle.
REQ-021 IDLE->FILL on frame_start=1 with ce=1; if din_valid=1 in that cycle, the sample SHALL be accepted as index 0.
REQ-022 In FILL, each din_valid=1 SHALL accept one sample at index cnt, and cnt SHALL increment modulo 2^LOG2N.
REQ-023 For an accepted sample, the next enabled edge SHALL present wr_en=1, wr_data=din and wr_addr=cnt (BITREV=0) or bitreverse(cnt) (BITREV=1); latency is exactly 1 enabled cycle.
REQ-024 wr_en SHALL be 0 on any enabled cycle without an accepted sample.
REQ-025 When the sample with cnt=2^LOG2N-1 is accepted, start SHALL be 1 on the enabled edge after the one that raises its wr_en, for exactly one enabled cycle, and bank SHALL toggle on that same edge.
REQ-026 After wrap-around the block SHALL stay in FILL, and the next din_valid SHALL be index 0 of the next frame with or without frame_start.
REQ-027 frame_start in FILL with cnt=0 SHALL be a normal frame start.
REQ-028 frame_start in FILL with cnt!=0 SHALL set short_frame, force the current sample (if valid) to index 0, and issue no start pulse for the aborted frame.
REQ-029 clear=1 with ce=1 SHALL return the block to IDLE, zero cnt, wr_en, start and bank, and clear short_frame; clear SHALL take priority over frame_start and din_valid in the same cycle.
REQ-030 clear SHALL act even when ce=0.
REQ-031 The counter SHALL be exactly LOG2N bits and wrap silently, with no overflow output.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, cnt=0, wr_en=0, wr_addr=0, wr_data=0, start=0, bank=0 and short_frame=0, independent of clock_c and ce.
REQ-033 Deassertion SHALL be synchronised internally with a 2-flop chain; the first active cycle is the second rising edge after reset_n rises.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame and produce no start pulse.

Structure
REQ-035 A shared package SHALL hold LOG2N/DW defaults, the state enum {IDLE, FILL}, and a bitreverse function reused by read-side stages.
REQ-036 Exactly one sub-module, fft_bitrev_addr (combinational, width-parameterised), SHALL generate the address.
REQ-037 A frame counter, the state register and the output registers SHALL live in the top module.

Verification
REQ-038 Continuous frame: reset, ce=1, frame_start plus 256 valid samples din=k -> wr_addr sequence 0,128,64,192,...,255; single start pulse 2 cycles after the last valid sample; bank 0->1.
REQ-039 ce gating: ce toggled 1010 during a frame -> identical wr_* sequence on enabled edges, no duplicate or missing writes, start still one enabled cycle.
REQ-040 Short frame: frame_start at sample 100 -> short_frame=1, that sample written at address 0, no start pulse until 256 further samples.
REQ-041 Clear priority: clear and frame_start in the same cycle with ce=0 -> IDLE, bank=0, short_frame=0, next din_valid ignored.
REQ-042 Async reset mid-frame: reset_n low at sample 37 -> outputs 0 immediately without a clock edge; after release, din_valid without frame_start produces no write.
REQ-043 BITREV=0 build: 2 back-to-back frames -> wr_addr 0..255 twice, two start pulses 256 enabled cycles apart, bank returns to 0.

Source files
------------

// File: rtl/fft_stage_write_ctrl_pkg.sv
// Shared definitions for the FFT stage write side: size defaults, state encoding
// and the bit-reversal helper also used by the read-side stages.
package fft_stage_write_ctrl_pkg;

    localparam int LOG2N_DEF = 8;
    localparam int DW_DEF    = 32;
    localparam int MAX_LOG2N = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitreverse(input logic [MAX_LOG2N-1:0] v,
                                                        input int unsigned w);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_write_ctrl_if.sv
// Sample-in / buffer-write bundle between a sample source, the write controller
// and the downstream ping-pong buffer.
interface fft_stage_write_ctrl_if
    import fft_stage_write_ctrl_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int DW    = DW_DEF
);
    logic             frame_start;
    logic             din_valid;
    logic [DW-1:0]    din;
    logic [DW-1:0]    wr_data;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_en;
    logic             start;
    logic             bank;

    modport master (
        output frame_start, din_valid, din,
        input  wr_data, wr_addr, wr_en, start, bank
    );

    modport slave (
        input  frame_start, din_valid, din,
        output wr_data, wr_addr, wr_en, start, bank
    );

endinterface

// File: rtl/fft_bitrev_addr.sv
// Combinational buffer address generator: bit-reversed or natural order of the
// sample index, selected at elaboration time.
module fft_bitrev_addr
    import fft_stage_write_ctrl_pkg::*;
#(
    parameter int W      = LOG2N_DEF,
    parameter int BITREV = 1
) (
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] addr_o
);

    generate
        if (BITREV != 0) begin : g_rev
            assign addr_o = W'(bitreverse(MAX_LOG2N'(idx_i), W));
        end else begin : g_nat
            assign addr_o = idx_i;
        end
    endgenerate

endmodule

// File: rtl/fft_stage_write_ctrl.sv
// FFT stage write controller: numbers incoming samples within a frame, writes them
// to the ping-pong buffer and pulses start once a complete frame has landed.
//
// state | meaning
// IDLE  | waiting for frame_start; din_valid alone is ignored
// FILL  | accepting samples, index cnt wraps into the next frame
module fft_stage_write_ctrl
    import fft_stage_write_ctrl_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int DW     = DW_DEF,
    parameter int BITREV = 1
) (
    input  logic                   clock_c,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   clear,
    fft_stage_write_ctrl_if.slave  bus,
    output logic                   short_frame
);

    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    logic             rst_meta_q;
    logic             rst_sync_q;

    state_e           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [LOG2N-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             last_q, last_d;
    logic             start_q, start_d;
    logic             bank_q, bank_d;
    logic             short_q, short_d;

    logic [LOG2N-1:0] idx;
    logic [LOG2N-1:0] addr;
    logic             accept;

    // Assertion reaches the datapath at once through rst_sync_q; release is delayed two edges.
    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // A frame_start always re-bases the current sample to index 0.
    assign idx = bus.frame_start ? '0 : cnt_q;

    fft_bitrev_addr #(
        .W      (LOG2N),
        .BITREV (BITREV)
    ) u_addr (
        .idx_i  (idx),
        .addr_o (addr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = wr_en_q;
        last_d    = last_q;
        start_d   = start_q;
        bank_d    = bank_q;
        short_d   = short_q;
        accept    = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            wr_en_d = 1'b0;
            last_d  = 1'b0;
            start_d = 1'b0;
            bank_d  = 1'b0;
            short_d = 1'b0;
        end else if (ce) begin
            wr_en_d = 1'b0;
            last_d  = 1'b0;
            start_d = last_q;
            bank_d  = bank_q ^ last_q;
            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        accept  = bus.din_valid;
                    end
                end
                FILL: begin
                    accept = bus.din_valid;
                    if (bus.frame_start) begin
                        cnt_d = '0;
                        if (cnt_q != '0) short_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (accept) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr;
                wr_data_d = bus.din;
                cnt_d     = idx + LOG2N'(1);
                last_d    = (idx == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clock_c or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            bank_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            last_q    <= last_d;
            start_q   <= start_d;
            bank_q    <= bank_d;
            short_q   <= short_d;
        end
    end

    assign bus.wr_data  = wr_data_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.start    = start_q;
    assign bus.bank     = bank_q;
    assign short_frame  = short_q;

endmodule

// File: tb/tb_fft_stage_write_ctrl.sv
// Bench for fft_stage_write_ctrl: a bit-reversed and a natural-order instance share
// one stimulus stream and are compared against a frame-level reference model.
module tb_fft_stage_write_ctrl;
    import fft_stage_write_ctrl_pkg::*;

    localparam int LOG2N = 8;
    localparam int DW    = 32;
    localparam int N     = 1 << LOG2N;

    logic clock_c = 1'b0;
    logic reset_n;
    logic ce;
    logic clear;
    logic short_br;
    logic short_nat;

    int n_checks = 0;
    int n_err    = 0;
    int starts_seen;

    fft_stage_write_ctrl_if #(.LOG2N(LOG2N), .DW(DW)) bus_br ();
    fft_stage_write_ctrl_if #(.LOG2N(LOG2N), .DW(DW)) bus_nat ();

    always #5 clock_c = ~clock_c;

    fft_stage_write_ctrl #(.LOG2N(LOG2N), .DW(DW), .BITREV(1)) u_dut_br (
        .clock_c     (clock_c),
        .reset_n     (reset_n),
        .ce          (ce),
        .clear       (clear),
        .bus         (bus_br.slave),
        .short_frame (short_br)
    );

    fft_stage_write_ctrl #(.LOG2N(LOG2N), .DW(DW), .BITREV(0)) u_dut_nat (
        .clock_c     (clock_c),
        .reset_n     (reset_n),
        .ce          (ce),
        .clear       (clear),
        .bus         (bus_nat.slave),
        .short_frame (short_nat)
    );

    // Reference model: frame position, last write and pending frame-complete event.
    bit            m_fill;
    int            m_cnt;
    int            m_idx;
    bit            m_due;
    logic          m_wr_en;
    logic          m_start;
    logic          m_bank;
    logic          m_short;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rev_idx(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    task automatic model_reset();
        m_fill  = 1'b0;
        m_cnt   = 0;
        m_idx   = 0;
        m_due   = 1'b0;
        m_wr_en = 1'b0;
        m_start = 1'b0;
        m_bank  = 1'b0;
        m_short = 1'b0;
        m_data  = '0;
    endtask

    task automatic model_step(input bit fs, input bit dv, input bit clr, input bit en,
                              input logic [DW-1:0] d);
        bit acc;
        if (clr) begin
            m_fill  = 1'b0;
            m_cnt   = 0;
            m_due   = 1'b0;
            m_wr_en = 1'b0;
            m_start = 1'b0;
            m_bank  = 1'b0;
            m_short = 1'b0;
        end else if (en) begin
            m_start = m_due;
            if (m_due) m_bank = ~m_bank;
            m_due = 1'b0;
            acc = dv && (m_fill || fs);
            if (fs) begin
                if (m_fill && m_cnt != 0) m_short = 1'b1;
                m_fill = 1'b1;
                m_cnt  = 0;
            end
            m_wr_en = acc;
            if (acc) begin
                m_idx  = m_cnt;
                m_data = d;
                if (m_cnt == N - 1) m_due = 1'b1;
                m_cnt  = (m_cnt + 1) % N;
            end
        end
    endtask

    task automatic check_all();
        check("wr_en_br", bus_br.wr_en, m_wr_en);
        check("wr_en_nat", bus_nat.wr_en, m_wr_en);
        if (m_wr_en) begin
            check("wr_addr_br", bus_br.wr_addr, rev_idx(m_idx));
            check("wr_addr_nat", bus_nat.wr_addr, m_idx);
            check("wr_data_br", bus_br.wr_data, m_data);
            check("wr_data_nat", bus_nat.wr_data, m_data);
        end
        check("start_br", bus_br.start, m_start);
        check("start_nat", bus_nat.start, m_start);
        check("bank_br", bus_br.bank, m_bank);
        check("bank_nat", bus_nat.bank, m_bank);
        check("short_br", short_br, m_short);
        check("short_nat", short_nat, m_short);
        if (bus_br.start && ce) starts_seen++;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_wr_en"}, bus_br.wr_en, 0);
        check({pfx, "_wr_addr"}, bus_br.wr_addr, 0);
        check({pfx, "_wr_data"}, bus_br.wr_data, 0);
        check({pfx, "_start"}, bus_br.start, 0);
        check({pfx, "_bank"}, bus_br.bank, 0);
        check({pfx, "_short"}, short_br, 0);
        check({pfx, "_nat_wr_en"}, bus_nat.wr_en, 0);
        check({pfx, "_nat_wr_data"}, bus_nat.wr_data, 0);
    endtask

    // Called at a falling edge; applies inputs, advances model on the rising edge, compares.
    task automatic tick(input bit fs, input bit dv, input bit clr, input bit en,
                        input logic [DW-1:0] d);
        ce                  = en;
        clear               = clr;
        bus_br.frame_start  = fs;
        bus_br.din_valid    = dv;
        bus_br.din          = d;
        bus_nat.frame_start = fs;
        bus_nat.din_valid   = dv;
        bus_nat.din         = d;
        @(posedge clock_c);
        model_step(fs, dv, clr, en, d);
        @(negedge clock_c);
        check_all();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock_c);
        @(negedge clock_c);
        reset_n = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    initial begin
        reset_n = 1'b1;
        ce      = 1'b0;
        clear   = 1'b0;
        bus_br.frame_start  = 1'b0;
        bus_br.din_valid    = 1'b0;
        bus_br.din          = '0;
        bus_nat.frame_start = 1'b0;
        bus_nat.din_valid   = 1'b0;
        bus_nat.din         = '0;
        starts_seen = 0;
        model_reset();

        #1 reset_n = 1'b0;
        #1 check_zero("por");
        release_reset();

        // Two back-to-back frames, din = k.
        starts_seen = 0;
        for (int k = 0; k < 2 * N; k++) begin
            tick(k == 0, 1'b1, 1'b0, 1'b1, DW'(k));
            if (k == 1) check("seq_addr1", bus_br.wr_addr, 128);
            if (k == 2) check("seq_addr2", bus_br.wr_addr, 64);
            if (k == 3) check("seq_addr3", bus_br.wr_addr, 192);
            if (k == N - 1) begin
                check("seq_addr_last", bus_br.wr_addr, 255);
                check("start_early", bus_br.start, 0);
            end
            if (k == N) begin
                check("start_frame1", bus_br.start, 1);
                check("bank_frame1", bus_br.bank, 1);
            end
            if (k == N + 1) check("start_once", bus_br.start, 0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("start_frame2", bus_nat.start, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("b2b_starts", starts_seen, 2);
        check("b2b_bank", bus_nat.bank, 0);

        // ce toggled 1010 while a frame streams in.
        starts_seen = 0;
        for (int k = 0; k < N; k++) begin
            tick(k == 0, 1'b1, 1'b0, 1'b1, DW'(k + 1000));
            tick(k == 0, 1'b1, 1'b0, 1'b0, DW'(k + 1000));
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, k[0] == 1'b0, '0);
        check("ce_starts", starts_seen, 1);
        check("ce_bank", bus_br.bank, 1);

        // frame_start at sample 100 aborts the frame in progress.
        starts_seen = 0;
        for (int k = 0; k < 100; k++) tick(k == 0, 1'b1, 1'b0, 1'b1, $urandom);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'hABCD_0100);
        check("short_addr", bus_br.wr_addr, 0);
        check("short_flag", short_br, 1);
        for (int k = 1; k < N; k++) tick(1'b0, 1'b1, 1'b0, 1'b1, $urandom);
        check("short_nostart", starts_seen, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("short_start", starts_seen, 1);

        // Clear beats frame_start with ce low; bank and short_frame set beforehand.
        for (int k = 0; k < N + 10; k++) tick(k == 0, 1'b1, 1'b0, 1'b1, $urandom);
        check("pre_clear_bank", bus_br.bank, 1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
        check("clr_bank", bus_br.bank, 0);
        check("clr_short", short_br, 0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, $urandom);
        check("clr_ignored", bus_br.wr_en, 0);

        // Asynchronous reset at sample 37.
        for (int k = 0; k < 37; k++) tick(k == 0, 1'b1, 1'b0, 1'b1, $urandom | 32'h1);
        #2 reset_n = 1'b0;
        #1 check_zero("arst");
        model_reset();
        release_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b1, $urandom);
        check("arst_ignored", bus_br.wr_en, 0);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            tick((k == 0) || ($urandom_range(0, 199) == 0),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 999) == 0,
                 $urandom_range(0, 4) != 0,
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
